even_parity_serial_tx: RTL and testbench
========================================

Name: even_parity_serial_tx

Overview:
- Transmit-side partner of the even-parity checker.
- Accepts a parallel data word over a valid/ready handshake and computes its even-parity bit.
- Serialises the word as a framed bit stream: start bit, data LSB-first, parity bit, stop bit.
- Sits upstream of the serial link whose receiver feeds the parity checker.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (≥1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_serial (≥1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset.
- in_data  input  DATA_WIDTH  word to transmit; sampled only on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- tx_serial  output  1  serial line; idles high.
- parity_out  output  1  even-parity bit of the last accepted word.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on frame completion.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, tx_serial=1, in_ready=1, busy=0, done=0, parity_out=0. Shift register and counters are cleared.
- Reset mid-frame aborts the frame immediately. tx_serial returns high asynchronously. The partial frame is not resumed.
- in_ready = (state==IDLE). busy = ~in_ready. Both are registered-state derived with no combinational path from in_valid.
- Accept = in_valid & in_ready at a rising edge. On accept:
  - in_data is latched into the shift register.
  - parity_out is registered as the XOR-reduction of in_data, so the ones-count of data plus parity is even.
  - state goes to START.
- in_valid or in_data changes while busy are ignored. The latched word is immutable for the frame.
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
  - Each state drives tx_serial for exactly CLKS_PER_BIT cycles, counted by a bit-timer that runs 0..CLKS_PER_BIT-1.
  - START drives 0.
  - DATA drives shift_reg[0] and shifts right at each bit boundary. A bit index 0..DATA_WIDTH-1 counts data bits; leave DATA after bit DATA_WIDTH-1 completes.
  - PARITY drives parity_out.
  - STOP drives 1.
  - IDLE drives 1.
- tx_serial is a registered output. The first start-bit cycle is the cycle immediately after the accept edge.
- Frame length is (DATA_WIDTH+3)*CLKS_PER_BIT cycles from the first start cycle to the last stop cycle.
- done: asserted for exactly one cycle, the first IDLE cycle after STOP. It is 0 at all other times, including after reset.
- Back-to-back: in_valid may be high in the done cycle. That word is accepted, and its start bit follows with no extra idle cycle.
- CLKS_PER_BIT=1: every state lasts one cycle. The bit-timer width must be at least 1 bit.
- parity_out holds its value until the next accept.
- Non-zero timer values in IDLE are impossible. The timer resets to 0 on every state transition.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → tx_serial=1, in_ready=1, busy=0, done=0, parity_out=0. Release → outputs unchanged with in_valid=0.
- Even-count word: DATA_WIDTH=8, CLKS_PER_BIT=4, send 8'hA5 (four ones).
  - parity_out=0.
  - tx_serial, sampled at each bit centre: 0 (start), 1,0,1,0,0,1,0,1 (data), 0 (parity), 1 (stop), each held 4 cycles.
  - busy is high for 44 cycles. done pulses once at cycle 45 after accept.
- Odd-count word: send 8'h07 → parity_out=1. Data bits on line 1,1,1,0,0,0,0,0, then parity 1 and stop 1.
- Ignore while busy: accept 8'h0F, then drive in_valid=1 with 8'hFF for the whole frame.
  - The line carries only 8'h0F with parity 0.
  - 8'hFF is accepted exactly in the done cycle, and its start bit follows with no gap.
  - The second frame carries parity 0.
- Reset mid-frame: assert rst_n=0 during the DATA state of 8'h3C.
  - tx_serial goes to 1 without waiting for a clock edge.
  - After release, in_ready=1 and done=0. A fresh 8'h01 then transmits with parity 1.
- CLKS_PER_BIT=1 build: send 8'h80 → 11-cycle frame 0,0,0,0,0,0,0,0,1,1,1 and done on cycle 12.

Source files
------------

// File: rtl/even_parity_serial_tx.sv
// even_parity_serial_tx
//   Accepts a parallel word over valid/ready, computes its even-parity bit and
//   serialises it as: start(0), data LSB-first, parity, stop(1). Each serial
//   bit is held on tx_serial for CLKS_PER_BIT clocks.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    word to transmit, sampled only on accept
//   in_valid   in_data is valid
//   in_ready   block can accept a word this cycle (state == IDLE)
//   tx_serial  registered serial line, idles high
//   parity_out even-parity bit of the last accepted word
//   busy       frame in progress
//   done       one-cycle pulse in the first IDLE cycle after STOP
module even_parity_serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx_serial,
  output logic                  parity_out,
  output logic                  busy,
  output logic                  done
);

  // Timer needs at least one bit even when CLKS_PER_BIT == 1.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1)   ? $clog2(DATA_WIDTH)   : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX = IW'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (timer_q == TMAX);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (in_valid) begin
          state_d   = START;
          shift_d   = in_data;
          parity_d  = ^in_data;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == IMAX) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
            shift_d   = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Line level is decoded from the *next* state so tx_serial is registered
  // yet the start bit appears in the cycle right after the accept edge.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign tx_serial  = tx_q;
  assign parity_out = parity_q;
  assign done       = done_q;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx. Main instance uses DATA_WIDTH=8,
// CLKS_PER_BIT=4; a second instance uses CLKS_PER_BIT=1. Accepted words are
// queued; a negedge monitor captures each busy window and compares it with
// the frame predicted from the word alone.
module tb_even_parity_serial_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FB  = DW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, tx_serial, parity_out, busy, done;

  logic [DW-1:0] c1_data = '0;
  logic c1_valid = 1'b0;
  logic c1_ready, c1_tx, c1_parity, c1_busy, c1_done;

  always #5 clk = ~clk;

  even_parity_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_serial(tx_serial), .parity_out(parity_out),
    .busy(busy), .done(done));

  even_parity_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(c1_data), .in_valid(c1_valid),
    .in_ready(c1_ready), .tx_serial(c1_tx), .parity_out(c1_parity),
    .busy(c1_busy), .done(c1_done));

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: bit k of the frame for word w.
  function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += w[i];
    if (k == 0) return 1'b0;
    if (k <= DW) return w[k-1];
    if (k == DW + 1) return logic'(ones % 2);
    return 1'b1;
  endfunction

  // Scoreboard push on every accept edge (inputs change only on negedges).
  always @(posedge clk)
    if (rst_n && in_valid && in_ready) sb.push_back(in_data);

  // Monitor
  logic cap[64];
  int   cyc = 0;
  bit   in_frame = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
    end else if (busy) begin
      if (!in_frame) begin in_frame = 1; cyc = 0; end
      if (cyc < 64) cap[cyc] = tx_serial;
      cyc++;
    end else if (in_frame) begin
      logic [DW-1:0] w;
      int ones;
      in_frame = 0;
      chk("frame_len", cyc, FB * CPB);
      chk("done_pulse", done, 1);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        w = sb.pop_front();
        ones = 0;
        for (int i = 0; i < DW; i++) ones += w[i];
        chk("parity_out", parity_out, ones % 2);
        for (int k = 0; k < FB; k++)
          if (k * CPB + CPB / 2 < 64)
            chk($sformatf("bit%0d_w%02h", k, w), cap[k * CPB + CPB / 2], frame_bit(w, k));
      end
    end else begin
      chk("done_idle", done, 0);
    end
  end

  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    in_data = w; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_serial, 1); chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_par", parity_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_tx", tx_serial, 1); chk("post_ready", in_ready, 1); chk("post_busy", busy, 0);

    // Directed words
    send(8'hA5); wait_idle(); @(negedge clk);
    send(8'h07); wait_idle(); @(negedge clk);

    // Ignore while busy, then back-to-back accept in the done cycle
    send(8'h0F);
    in_data = 8'hFF; in_valid = 1'b1;
    begin
      int n = 0;
      while (!done && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("done_timeout", 0, 1);
    end
    @(negedge clk);
    chk("b2b_busy", busy, 1); chk("b2b_start", tx_serial, 0);
    in_valid = 1'b0;
    wait_idle(); @(negedge clk);

    // Reset mid-frame during DATA of 8'h3C
    send(8'h3C);
    repeat (CPB + 2) @(negedge clk);
    chk("mid_tx_low", tx_serial, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_tx", tx_serial, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", in_ready, 1); chk("abort_done", done, 0);
    send(8'h01); wait_idle(); @(negedge clk);

    // Randomized traffic with noise on inputs while busy
    for (int t = 0; t < 20; t++) begin
      send(DW'($urandom));
      for (int g = 0; g < 50 && busy; g++) begin
        in_data = DW'($urandom); in_valid = 1'b0;
        @(negedge clk);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(); repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    // CLKS_PER_BIT=1 instance: 8'h80
    c1_data = 8'h80; c1_valid = 1'b1;
    @(negedge clk);
    c1_valid = 1'b0;
    for (int k = 0; k < FB; k++) begin
      chk($sformatf("c1_bit%0d", k), c1_tx, frame_bit(8'h80, k));
      @(negedge clk);
    end
    chk("c1_done", c1_done, 1); chk("c1_busy", c1_busy, 0); chk("c1_par", c1_parity, 1);
    @(negedge clk);
    chk("c1_done_off", c1_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
